id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter DATA_W, 8, datapath width; only 8 is supported.
REQ-002 Parameter NREG, 4, register-file entries, addressed by 2-bit fields.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 if_valid  in  1  fetch byte valid.
REQ-006 if_instr  in  8  fetch byte: op[7:4], ra[3:2], rb[1:0]; or LOADIMM immediate byte.
REQ-007 id_ready  out  1  fetch byte accepted when if_valid && id_ready.
REQ-008 wb_we, wb_rd[1:0], wb_data[7:0]  in  writeback port into the register file.
REQ-009 flush  in  1  squash decode state and all in-flight issue.
REQ-010 ex_ready  in  1  EXE accepts the output slot.
REQ-011 ex_valid  out  1  output slot holds an instruction.
REQ-012 ex_op[3:0], ex_s1[7:0], ex_s2[7:0], ex_imm[7:0], ex_rd[1:0], ex_wen  out  registered EXE operands.
REQ-013 illegal  out  1  one-cycle pulse when op 9..D is accepted.

Function
REQ-014 Op classes: writers ra = 1,2,3,4,5,7,8,F; non-writers = 6,E; NOP = 0; illegal = 9..D.
REQ-015 Sources: 1,2,3,E read ra and rb; 4,5,6 read ra; 8 reads rb; 7,F read nothing.
REQ-016 ex_s1 = R[ra], ex_s2 = R[rb]; unused operand fields and ex_imm drive 0 when unused.
REQ-017 FSM S_OP: accepting op F stores ra, goes to S_IMM, and issues nothing.
REQ-018 FSM S_IMM: next accepted byte becomes ex_imm and issues op F with ex_rd = stored ra; FSM returns to S_OP.
REQ-019 NOP and illegal bytes are consumed without issue; illegal also pulses illegal.
REQ-020 Issue latency: an accepted byte that completes an instruction sets ex_valid on the next cycle.
REQ-021 ex_valid and ex_* fields hold stable until ex_ready is high.
REQ-022 Slot free = !ex_valid || ex_ready.
REQ-023 Scoreboard: one busy bit per register, set when a writer issues into the slot, cleared on wb_we for wb_rd.
REQ-024 Hazard = any source register busy and not being written by wb_we in the same cycle.
REQ-025 id_ready = slot free && !hazard in S_OP; id_ready = slot free in S_IMM.
REQ-026 Register file writes on wb_we; a same-cycle read of wb_rd returns wb_data (write-first bypass).
REQ-027 Writeback to a non-busy register writes data and leaves the scoreboard unchanged.
REQ-028 Simultaneous issue-set and wb-clear on the same register: set wins.
REQ-029 flush: next cycle ex_valid=0, FSM=S_OP, all busy bits=0; register contents are kept; id_ready=0 during the flush cycle.
REQ-030 flush has priority over issue, stall and writeback-clear; a wb_we write in the flush cycle still updates the register file.

Reset
REQ-031 rst: ex_valid=0, ex_* fields=0, illegal=0, FSM=S_OP, busy=0, all registers=0.
REQ-032 rst mid-LOADIMM abandons the stored ra; no partial issue occurs.
REQ-033 rst has priority over flush and all other inputs.

Structure
REQ-034 Shared package holds opcode constants (OP_NOP..OP_LOADIMM), op-class helper functions and the FSM state enum.
REQ-035 Sub-module regfile (NREG x DATA_W, 2 read ports, 1 write port, write-first bypass) is instantiated once.
REQ-036 Scoreboard, FSM and output slot are implemented inside id_stage.

Verification
REQ-037 After rst, wb R1=0x05, R2=0x03, then byte 0x16 (ADD r1,r2) -> next cycle ex_valid=1, op=1, s1=0x05, s2=0x03, rd=1, wen=1.
REQ-038 0xF8 then 0x7F -> no issue after first byte; after second: op=F, imm=0x7F, rd=2, busy[2]=1.
REQ-039 Issue writer to R1, then byte 0x44 (SHL r1) with no writeback -> id_ready=0; wb_we R1=0x81 -> in the same cycle id_ready=1 and s1=0x81.
REQ-040 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* fields unchanged and id_ready=0; ex_ready=1 -> next byte is accepted.
REQ-041 flush in S_IMM with busy[0]=1 -> FSM=S_OP, ex_valid=0, busy=0; byte 0x90 -> illegal pulses and no issue.
REQ-042 rst asserted while ex_valid=1 and ex_ready=0 -> next cycle all outputs 0 and FSM=S_OP.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the 8-bit decode/issue stage:
// opcodes, op-class helpers and the decode FSM state.
package id_stage_pkg;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_ADD     = 4'h1;
    localparam logic [3:0] OP_SUB     = 4'h2;
    localparam logic [3:0] OP_AND     = 4'h3;
    localparam logic [3:0] OP_SHL     = 4'h4;
    localparam logic [3:0] OP_SHR     = 4'h5;
    localparam logic [3:0] OP_TST     = 4'h6;
    localparam logic [3:0] OP_CLR     = 4'h7;
    localparam logic [3:0] OP_MOV     = 4'h8;
    localparam logic [3:0] OP_CMP     = 4'hE;
    localparam logic [3:0] OP_LOADIMM = 4'hF;

    typedef enum logic {
        S_OP,
        S_IMM
    } state_e;

    function automatic logic op_writes(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_SHL,
                          OP_SHR, OP_CLR, OP_MOV, OP_LOADIMM};
    endfunction

    function automatic logic op_illegal(input logic [3:0] op);
        return (op >= 4'h9) && (op <= 4'hD);
    endfunction

    function automatic logic op_reads_ra(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_CMP,
                          OP_SHL, OP_SHR, OP_TST};
    endfunction

    function automatic logic op_reads_rb(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_CMP, OP_MOV};
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Register file: NREG x DATA_W, two read ports, one write port,
// write-first bypass so a same-cycle read sees the writeback data.
module id_stage_regfile #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      we_i,
    input  logic [$clog2(NREG)-1:0]   waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [$clog2(NREG)-1:0]   raddr_a_i,
    input  logic [$clog2(NREG)-1:0]   raddr_b_i,
    output logic [DATA_W-1:0]         rdata_a_o,
    output logic [DATA_W-1:0]         rdata_b_o
);

    logic [DATA_W-1:0] mem_q [NREG];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (we_i && waddr_i == raddr_a_i) ? wdata_i : mem_q[raddr_a_i];
    assign rdata_b_o = (we_i && waddr_i == raddr_b_i) ? wdata_i : mem_q[raddr_b_i];

endmodule

// File: rtl/id_stage.sv
// Decode/issue stage: byte-wide fetch, two-byte LOADIMM, busy-bit
// scoreboard for RAW hazards and a single registered EXE slot.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [7:0]        if_instr,
    output logic              id_ready,
    input  logic              wb_we,
    input  logic [1:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [3:0]        ex_op,
    output logic [DATA_W-1:0] ex_s1,
    output logic [DATA_W-1:0] ex_s2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [1:0]        ex_rd,
    output logic              ex_wen,
    output logic              illegal
);

    logic [3:0]        op;
    logic [1:0]        ra;
    logic [1:0]        rb;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    state_e            state_q, state_d;
    logic [1:0]        ra_q, ra_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              ex_valid_q, ex_valid_d;
    logic [3:0]        ex_op_q, ex_op_d;
    logic [DATA_W-1:0] ex_s1_q, ex_s1_d;
    logic [DATA_W-1:0] ex_s2_q, ex_s2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [1:0]        ex_rd_q, ex_rd_d;
    logic              ex_wen_q, ex_wen_d;
    logic              illegal_q, illegal_d;

    logic              haz_a;
    logic              haz_b;
    logic              slot_free;
    logic              accept;
    logic              issue;

    assign op = if_instr[7:4];
    assign ra = if_instr[3:2];
    assign rb = if_instr[1:0];

    id_stage_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_rf (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (wb_we),
        .waddr_i   (wb_rd),
        .wdata_i   (wb_data),
        .raddr_a_i (ra),
        .raddr_b_i (rb),
        .rdata_a_o (rd_a),
        .rdata_b_o (rd_b)
    );

    // A writeback landing this cycle resolves the hazard via the bypass.
    assign haz_a = op_reads_ra(op) && busy_q[ra] && !(wb_we && wb_rd == ra);
    assign haz_b = op_reads_rb(op) && busy_q[rb] && !(wb_we && wb_rd == rb);

    assign slot_free = !ex_valid_q || ex_ready;
    assign id_ready  = !rst && !flush && slot_free &&
                       (state_q == S_IMM || !(haz_a || haz_b));
    assign accept    = if_valid && id_ready;

    always_comb begin
        state_d    = state_q;
        ra_d       = ra_q;
        busy_d     = busy_q;
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_s1_d    = ex_s1_q;
        ex_s2_d    = ex_s2_q;
        ex_imm_d   = ex_imm_q;
        ex_rd_d    = ex_rd_q;
        ex_wen_d   = ex_wen_q;
        illegal_d  = 1'b0;
        issue      = 1'b0;

        if (ex_ready) ex_valid_d = 1'b0;
        if (wb_we) busy_d[wb_rd] = 1'b0;

        if (accept) begin
            unique case (state_q)
                S_OP: begin
                    if (op == OP_LOADIMM) begin
                        state_d = S_IMM;
                        ra_d    = ra;
                    end else if (op_illegal(op)) begin
                        illegal_d = 1'b1;
                    end else if (op != OP_NOP) begin
                        issue    = 1'b1;
                        ex_op_d  = op;
                        ex_s1_d  = op_reads_ra(op) ? rd_a : '0;
                        ex_s2_d  = op_reads_rb(op) ? rd_b : '0;
                        ex_imm_d = '0;
                        ex_rd_d  = op_writes(op) ? ra : 2'd0;
                        ex_wen_d = op_writes(op);
                    end
                end
                S_IMM: begin
                    state_d  = S_OP;
                    issue    = 1'b1;
                    ex_op_d  = OP_LOADIMM;
                    ex_s1_d  = '0;
                    ex_s2_d  = '0;
                    ex_imm_d = if_instr;
                    ex_rd_d  = ra_q;
                    ex_wen_d = 1'b1;
                end
            endcase
        end

        // Applied after the writeback clear so a same-register set wins.
        if (issue) begin
            ex_valid_d = 1'b1;
            if (ex_wen_d) busy_d[ex_rd_d] = 1'b1;
        end

        if (flush) begin
            ex_valid_d = 1'b0;
            state_d    = S_OP;
            busy_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OP;
            ra_q       <= '0;
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_s1_q    <= '0;
            ex_s2_q    <= '0;
            ex_imm_q   <= '0;
            ex_rd_q    <= '0;
            ex_wen_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ra_q       <= ra_d;
            busy_q     <= busy_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_s1_q    <= ex_s1_d;
            ex_s2_q    <= ex_s2_d;
            ex_imm_q   <= ex_imm_d;
            ex_rd_q    <= ex_rd_d;
            ex_wen_q   <= ex_wen_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_op    = ex_op_q;
    assign ex_s1    = ex_s1_q;
    assign ex_s2    = ex_s2_q;
    assign ex_imm   = ex_imm_q;
    assign ex_rd    = ex_rd_q;
    assign ex_wen   = ex_wen_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: vector table for single-byte decode plus
// hand sequences for LOADIMM, hazards, stalls, flush and reset.
module tb_id_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_valid;
    logic [7:0] if_instr;
    logic       id_ready;
    logic       wb_we;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic       flush;
    logic       ex_ready;
    logic       ex_valid;
    logic [3:0] ex_op;
    logic [7:0] ex_s1;
    logic [7:0] ex_s2;
    logic [7:0] ex_imm;
    logic [1:0] ex_rd;
    logic       ex_wen;
    logic       illegal;

    typedef struct {
        logic [3:0] op;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] imm;
        logic [1:0] rd;
        logic       wen;
    } slot_t;

    typedef struct {
        logic [7:0] instr;
        logic       iss;
        slot_t      exp;
        logic       ill;
    } vec_t;

    slot_t      sb_q[$];
    vec_t       vt[13];
    logic [7:0] m[4];
    int         n_tests = 0;
    int         n_fail  = 0;

    id_stage #(.DATA_W(8), .NREG(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .id_ready (id_ready),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .flush    (flush),
        .ex_ready (ex_ready),
        .ex_valid (ex_valid),
        .ex_op    (ex_op),
        .ex_s1    (ex_s1),
        .ex_s2    (ex_s2),
        .ex_imm   (ex_imm),
        .ex_rd    (ex_rd),
        .ex_wen   (ex_wen),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    function automatic slot_t mk(input logic [3:0] op, input logic [7:0] s1,
                                 input logic [7:0] s2, input logic [7:0] imm,
                                 input logic [1:0] rd, input logic wen);
        slot_t s;
        s.op = op; s.s1 = s1; s.s2 = s2; s.imm = imm; s.rd = rd; s.wen = wen;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected issue (if any), then pop and compare whatever the slot holds.
    task automatic chk_slot(input string nm, input logic iss, input slot_t e);
        slot_t g;
        chk({nm, ".valid"}, 32'(ex_valid), 32'(iss));
        if (iss) sb_q.push_back(e);
        if (ex_valid) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s.extra: got issue op 0x%0h expected none", nm, ex_op);
            end else begin
                g = sb_q.pop_front();
                chk({nm, ".op"},  32'(ex_op),  32'(g.op));
                chk({nm, ".s1"},  32'(ex_s1),  32'(g.s1));
                chk({nm, ".s2"},  32'(ex_s2),  32'(g.s2));
                chk({nm, ".imm"}, 32'(ex_imm), 32'(g.imm));
                chk({nm, ".rd"},  32'(ex_rd),  32'(g.rd));
                chk({nm, ".wen"}, 32'(ex_wen), 32'(g.wen));
            end
        end else begin
            sb_q.delete();
        end
    endtask

    task automatic wb_cycle(input logic [1:0] r, input logic [7:0] d);
        wb_we = 1'b1; wb_rd = r; wb_data = d;
        tick();
        wb_we = 1'b0;
        m[r] = d;
    endtask

    task automatic send(input logic [7:0] b);
        if_valid = 1'b1;
        if_instr = b;
        #1 chk($sformatf("rdy_%02h", b), 32'(id_ready), 32'd1);
        tick();
        if_valid = 1'b0;
    endtask

    initial begin
        slot_t z;
        z = mk(4'h0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
        rst = 1'b1; if_valid = 1'b0; if_instr = 8'h00; wb_we = 1'b0;
        wb_rd = 2'd0; wb_data = 8'h00; flush = 1'b0; ex_ready = 1'b1;
        for (int i = 0; i < 4; i++) m[i] = 8'h00;

        vt[0]  = '{8'h16, 1'b1, mk(4'h1, 8'h05, 8'h03, 8'h00, 2'd1, 1'b1), 1'b0};
        vt[1]  = '{8'h2B, 1'b1, mk(4'h2, 8'h03, 8'h80, 8'h00, 2'd2, 1'b1), 1'b0};
        vt[2]  = '{8'h30, 1'b1, mk(4'h3, 8'h11, 8'h11, 8'h00, 2'd0, 1'b1), 1'b0};
        vt[3]  = '{8'h47, 1'b1, mk(4'h4, 8'h05, 8'h00, 8'h00, 2'd1, 1'b1), 1'b0};
        vt[4]  = '{8'h5E, 1'b1, mk(4'h5, 8'h80, 8'h00, 8'h00, 2'd3, 1'b1), 1'b0};
        vt[5]  = '{8'h69, 1'b1, mk(4'h6, 8'h03, 8'h00, 8'h00, 2'd0, 1'b0), 1'b0};
        vt[6]  = '{8'h7D, 1'b1, mk(4'h7, 8'h00, 8'h00, 8'h00, 2'd3, 1'b1), 1'b0};
        vt[7]  = '{8'h8A, 1'b1, mk(4'h8, 8'h00, 8'h03, 8'h00, 2'd2, 1'b1), 1'b0};
        vt[8]  = '{8'hE6, 1'b1, mk(4'hE, 8'h05, 8'h03, 8'h00, 2'd0, 1'b0), 1'b0};
        vt[9]  = '{8'h00, 1'b0, z, 1'b0};
        vt[10] = '{8'h9F, 1'b0, z, 1'b1};
        vt[11] = '{8'hD5, 1'b0, z, 1'b1};
        vt[12] = '{8'hA0, 1'b0, z, 1'b1};

        tick(); tick();
        chk("rst.valid", 32'(ex_valid), 32'd0);
        chk("rst.op",    32'(ex_op),    32'd0);
        chk("rst.s1",    32'(ex_s1),    32'd0);
        chk("rst.s2",    32'(ex_s2),    32'd0);
        chk("rst.imm",   32'(ex_imm),   32'd0);
        chk("rst.rd",    32'(ex_rd),    32'd0);
        chk("rst.wen",   32'(ex_wen),   32'd0);
        chk("rst.ill",   32'(illegal),  32'd0);
        rst = 1'b0;

        // Registers come out of reset as zero.
        send(8'h30);
        chk_slot("rst_regs", 1'b1, mk(4'h3, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1));
        wb_cycle(2'd0, 8'h11);
        chk_slot("drain0", 1'b0, z);
        wb_cycle(2'd1, 8'h05);
        wb_cycle(2'd2, 8'h03);
        wb_cycle(2'd3, 8'h80);

        foreach (vt[i]) begin
            send(vt[i].instr);
            chk_slot($sformatf("vec%0d", i), vt[i].iss, vt[i].exp);
            chk($sformatf("vec%0d.ill", i), 32'(illegal), 32'(vt[i].ill));
            if (vt[i].iss && vt[i].exp.wen) begin
                wb_we = 1'b1; wb_rd = vt[i].exp.rd; wb_data = m[vt[i].exp.rd];
            end
            tick();
            wb_we = 1'b0;
            chk($sformatf("vec%0d.pulse", i), 32'(illegal), 32'd0);
            chk_slot($sformatf("vec%0d.drain", i), 1'b0, z);
        end

        // LOADIMM: first byte issues nothing, second carries the immediate.
        send(8'hF8);
        chk_slot("ldi1", 1'b0, z);
        send(8'h7F);
        chk_slot("ldi2", 1'b1, mk(4'hF, 8'h00, 8'h00, 8'h7F, 2'd2, 1'b1));
        if_valid = 1'b1; if_instr = 8'h48;
        #1 chk("ldi_busy", 32'(id_ready), 32'd0);
        tick();
        chk_slot("ldi_stall", 1'b0, z);
        // Writeback of the busy source releases the stall in the same cycle.
        wb_we = 1'b1; wb_rd = 2'd2; wb_data = 8'h81;
        #1 chk("wb_release", 32'(id_ready), 32'd1);
        tick();
        if_valid = 1'b0; wb_we = 1'b0; m[2] = 8'h81;
        chk_slot("bypass", 1'b1, mk(4'h4, 8'h81, 8'h00, 8'h00, 2'd2, 1'b1));
        // The issue set busy[2] while the writeback cleared it.
        if_instr = 8'h48;
        #1 chk("set_wins", 32'(id_ready), 32'd0);
        wb_cycle(2'd2, 8'h03);
        chk_slot("drain1", 1'b0, z);
        #1 chk("busy2_clr", 32'(id_ready), 32'd1);

        // Back-pressure holds the slot and blocks decode.
        send(8'hE6);
        if_valid = 1'b1; if_instr = 8'h00; ex_ready = 1'b0;
        chk_slot("hold0", 1'b1, mk(4'hE, 8'h05, 8'h03, 8'h00, 2'd0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("hold_rdy%0d", k), 32'(id_ready), 32'd0);
            tick();
            chk_slot($sformatf("hold%0d", k + 1), 1'b1,
                     mk(4'hE, 8'h05, 8'h03, 8'h00, 2'd0, 1'b0));
        end
        ex_ready = 1'b1;
        #1 chk("release_rdy", 32'(id_ready), 32'd1);
        tick();
        if_valid = 1'b0;
        chk_slot("release", 1'b0, z);

        // Flush in S_IMM with busy[0] set; a writeback in the flush cycle still lands.
        send(8'h30);
        chk_slot("pre_flush", 1'b1, mk(4'h3, 8'h11, 8'h11, 8'h00, 2'd0, 1'b1));
        send(8'hF4);
        chk_slot("pre_flush_ldi", 1'b0, z);
        flush = 1'b1; if_valid = 1'b1; if_instr = 8'h55;
        wb_we = 1'b1; wb_rd = 2'd3; wb_data = 8'h42;
        #1 chk("flush_rdy", 32'(id_ready), 32'd0);
        tick();
        flush = 1'b0; wb_we = 1'b0; if_valid = 1'b0; m[3] = 8'h42;
        chk_slot("flush", 1'b0, z);
        send(8'h90);
        chk_slot("post_flush", 1'b0, z);
        chk("flush_ill", 32'(illegal), 32'd1);
        if_instr = 8'h40;
        #1 chk("busy_flushed", 32'(id_ready), 32'd1);
        send(8'h6C);
        chk_slot("flush_wb", 1'b1, mk(4'h6, 8'h42, 8'h00, 8'h00, 2'd0, 1'b0));
        chk("post_flush_ill", 32'(illegal), 32'd0);
        ex_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; ex_ready = 1'b1;
        chk_slot("flush_slot", 1'b0, z);

        // Reset mid-LOADIMM drops the stored ra; next byte is an opcode.
        send(8'hF4);
        chk_slot("rst_ldi0", 1'b0, z);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
        send(8'h16);
        chk_slot("rst_ldi", 1'b1, mk(4'h1, 8'h00, 8'h00, 8'h00, 2'd1, 1'b1));

        // Reset while the slot is held under back-pressure.
        ex_ready = 1'b0;
        tick();
        chk_slot("rst_hold", 1'b1, mk(4'h1, 8'h00, 8'h00, 8'h00, 2'd1, 1'b1));
        rst = 1'b1;
        tick();
        chk_slot("rst_slot", 1'b0, z);
        chk("rst2.op",  32'(ex_op),   32'd0);
        chk("rst2.s1",  32'(ex_s1),   32'd0);
        chk("rst2.rd",  32'(ex_rd),   32'd0);
        chk("rst2.wen", 32'(ex_wen),  32'd0);
        chk("rst2.ill", 32'(illegal), 32'd0);
        rst = 1'b0; ex_ready = 1'b1; if_instr = 8'h16;
        #1 chk("rst2.busy", 32'(id_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
